// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  localparam int DEF_DEPTH     = 512;
  localparam int DEF_AF_MARGIN = 4;
  localparam int DEF_AE_THRESH = 4;

  // One extra MSB beyond the index lets full and empty be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: clocked write port, combinational read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, almost flags, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int FWFT       = MODE_STD,
  parameter int AF_THRESH  = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_flush,
  input  logic                        i_clr_err,
  input  logic                        i_wr_en,
  input  logic [DATA_WIDTH-1:0]       i_wr_data,
  output logic                        o_full,
  output logic                        o_almost_full,
  input  logic                        i_rd_en,
  output logic [DATA_WIDTH-1:0]       o_rd_data,
  output logic                        o_empty,
  output logic                        o_almost_empty,
  output logic [ptr_width(DEPTH)-1:0] o_count,
  output logic                        o_overflow,
  output logic                        o_underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_set;
  logic                  udf_set;
  logic                  ovf_q;
  logic                  udf_q;

  // Flags come from the registered count only, never from this cycle's requests.
  assign o_full         = (count == PW'(DEPTH));
  assign o_empty        = (count == '0);
  assign o_almost_full  = (count >= PW'(AF_THRESH));
  assign o_almost_empty = (count <= PW'(AE_THRESH));
  assign o_count        = count;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

  // Flush discards same-cycle traffic, including its error reporting.
  assign wr_acc  = i_wr_en && !o_full  && !i_flush;
  assign rd_acc  = i_rd_en && !o_empty && !i_flush;
  assign ovf_set = i_wr_en && o_full  && !i_flush;
  assign udf_set = i_rd_en && o_empty && !i_flush;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (wr_acc),
    .i_wr_addr (wr_ptr[AW-1:0]),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_ptr[AW-1:0]),
    .o_rd_data (mem_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Last popped word: the registered output in standard mode, the idle value in FWFT.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)     rd_q <= '0;
    else if (rd_acc) rd_q <= mem_rdata;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set)        ovf_q <= 1'b1;
      else if (i_clr_err) ovf_q <= 1'b0;
      if (udf_set)        udf_q <= 1'b1;
      else if (i_clr_err) udf_q <= 1'b0;
    end
  end

  always_comb begin
    o_rd_data = rd_q;
    if (FWFT == MODE_FWFT && !o_empty) o_rd_data = mem_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: standard and FWFT instances share one stimulus stream.
module tb_sync_fifo_fwft;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush, clr, wr, rd;
  logic [DW-1:0] wd;

  logic          s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_count;
  logic          f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [DW-1:0] f_data;
  logic [CW-1:0] f_count;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0),
                   .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_clr_err(clr),
    .i_wr_en(wr), .i_wr_data(wd), .o_full(s_full), .o_almost_full(s_af),
    .i_rd_en(rd), .o_rd_data(s_data), .o_empty(s_empty), .o_almost_empty(s_ae),
    .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1),
                   .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_clr_err(clr),
    .i_wr_en(wr), .i_wr_data(wd), .o_full(f_full), .o_almost_full(f_af),
    .i_rd_en(rd), .o_rd_data(f_data), .o_empty(f_empty), .o_almost_empty(f_ae),
    .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq [$];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] std_hold;
  logic [DW-1:0] fwft_last;
  logic          m_ovf, m_udf;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          f;
    logic          c;
    int            cnt;
    logic          emp;
    logic          udf;
    logic [DW-1:0] sdat;
    logic [DW-1:0] fdat;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    std_hold  = '0;
    fwft_last = '0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("s_count", 32'(s_count), 32'(n));
    chk("f_count", 32'(f_count), 32'(n));
    chk("s_empty", 32'(s_empty), 32'(n == 0));
    chk("f_empty", 32'(f_empty), 32'(n == 0));
    chk("s_full",  32'(s_full),  32'(n == DEPTH));
    chk("f_full",  32'(f_full),  32'(n == DEPTH));
    chk("s_af",    32'(s_af),    32'(n >= AF));
    chk("f_af",    32'(f_af),    32'(n >= AF));
    chk("s_ae",    32'(s_ae),    32'(n <= AE));
    chk("f_ae",    32'(f_ae),    32'(n <= AE));
    chk("s_ovf",   32'(s_ovf),   32'(m_ovf));
    chk("f_ovf",   32'(f_ovf),   32'(m_ovf));
    chk("s_udf",   32'(s_udf),   32'(m_udf));
    chk("f_udf",   32'(f_udf),   32'(m_udf));
    if (sb.size() != 0) std_hold = sb.pop_front();
    chk("s_rd_data", 32'(s_data), 32'(std_hold));
    chk("f_rd_data", 32'(f_data), 32'((n != 0) ? mq[0] : fwft_last));
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic c);
    logic wa, ra, os, us;
    wa = w && (mq.size() != DEPTH) && !f;
    ra = r && (mq.size() != 0) && !f;
    os = w && (mq.size() == DEPTH) && !f;
    us = r && (mq.size() == 0) && !f;
    if (ra) sb.push_back(mq[0]);
    wr = w; wd = d; rd = r; flush = f; clr = c;
    @(posedge clk);
    #1;
    m_ovf = os ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_udf = us ? 1'b1 : (c ? 1'b0 : m_udf);
    if (f) mq.delete();
    else begin
      if (ra) fwft_last = mq.pop_front();
      if (wa) mq.push_back(d);
    end
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_empty"}, 32'(s_empty), 32'd1);
    chk({tag, "_f_empty"}, 32'(f_empty), 32'd1);
    chk({tag, "_s_full"},  32'(s_full),  32'd0);
    chk({tag, "_s_count"}, 32'(s_count), 32'd0);
    chk({tag, "_f_count"}, 32'(f_count), 32'd0);
    chk({tag, "_s_ae"},    32'(s_ae),    32'd1);
    chk({tag, "_s_af"},    32'(s_af),    32'd0);
    chk({tag, "_s_data"},  32'(s_data),  32'd0);
    chk({tag, "_f_data"},  32'(f_data),  32'd0);
    chk({tag, "_s_ovf"},   32'(s_ovf),   32'd0);
    chk({tag, "_s_udf"},   32'(s_udf),   32'd0);
    chk({tag, "_f_ovf"},   32'(f_ovf),   32'd0);
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic mid_cycle_reset(input string tag);
    #2 rstn = 1'b0;
    #1 check_reset_values(tag);
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; wd = '0;
    model_reset();

    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 8'h11};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00, 8'h11};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h11, 8'h22};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h22, 8'h33};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h33, 8'h33};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 8'h33, 8'h33};
    tbl[6] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'h33, 8'h44};
    tbl[7] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'h33, 8'h33};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h33, 8'h33};

    repeat (2) @(posedge clk);
    #1 check_reset_values("por");
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].f, tbl[i].c);
      chk($sformatf("tbl%0d_count", i), 32'(s_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(f_empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_udf", i),   32'(s_udf),   32'(tbl[i].udf));
      chk($sformatf("tbl%0d_sdat", i),  32'(s_data),  32'(tbl[i].sdat));
      chk($sformatf("tbl%0d_fdat", i),  32'(f_data),  32'(tbl[i].fdat));
    end

    // Fill to full, overflow, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 10) chk("af_before_12th", 32'(s_af), 32'd0);
      if (i == 11) chk("af_after_12th",  32'(s_af), 32'd1);
    end
    chk("full_after_16", 32'(s_full), 32'd1);
    chk("count_16", 32'(s_count), 32'd16);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("count_stays_16", 32'(s_count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk($sformatf("drain%0d", i), 32'(s_data), 32'(i));
    end

    // FWFT fall-through latency.
    step(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
    chk("fwft_not_empty", 32'(f_empty), 32'd0);
    chk("fwft_head", 32'(f_data), 32'h5C);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fwft_empty_after_pop", 32'(f_empty), 32'd1);
    chk("fwft_hold", 32'(f_data), 32'h5C);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(s_ovf), 32'd0);

    // Steady simultaneous read/write at count 8.
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      chk("rw_count_8", 32'(s_count), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Read+write on empty: only the write lands.
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("rw_empty_udf", 32'(s_udf), 32'd1);
    chk("rw_empty_count", 32'(s_count), 32'd1);

    // Flush at count 10 with a write pending.
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    chk("count_10", 32'(s_count), 32'd10);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(s_count), 32'd0);
    chk("flush_empty", 32'(s_empty), 32'd1);
    chk("flush_no_ovf", 32'(s_ovf), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_udf", 32'(s_udf), 32'd0);

    // Reset asserted mid-burst.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hE1, 1'b1, 1'b0, 1'b0);
    wr = 1'b1; wd = 8'hE2; rd = 1'b1;
    mid_cycle_reset("mid");

    // Random soak with alternating fill/drain bias.
    for (int i = 0; i < 5000; i++) begin
      int pw;
      pw = ((i / 250) % 2 == 0) ? 75 : 30;
      step($urandom_range(0, 99) < pw, 8'($urandom),
           $urandom_range(0, 99) < (100 - pw),
           $urandom_range(0, 299) == 0,
           $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
